// File: rtl/mult_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM state encoding and default width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int WIDTH_DEFAULT = 32;

endpackage

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier: one Booth step per RUN cycle, signed 2*WIDTH-bit product
// presented with a one-cycle endMult pulse.
module mult_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               workMult,
  input  logic [WIDTH-1:0]   oper_A,
  input  logic [WIDTH-1:0]   oper_B,
  output logic               busy,
  output logic               endMult,
  output logic [2*WIDTH-1:0] mul
);

  localparam int CW = $clog2(WIDTH) + 1;

  mult_state_t        state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] mul_q, mul_d;
  logic               end_q, end_d;
  logic               busy_q, busy_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    // A and M carry one guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
    unique case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase

    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    count_d = count_q;
    mul_d   = mul_q;
    end_d   = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (workMult) begin
          m_d     = {oper_A[WIDTH-1], oper_A};
          q_d     = oper_B;
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (count_q == CW'(WIDTH)) begin
          mul_d   = {a_q[WIDTH-1:0], q_q};
          end_d   = 1'b1;
          state_d = DONE;
        end else begin
          a_d     = {sum[WIDTH], sum[WIDTH:1]};
          q_d     = {sum[0], q_q[WIDTH-1:1]};
          q1_d    = q_q[0];
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      mul_q   <= '0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      count_q <= count_d;
      mul_q   <= mul_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign endMult = end_q;
  assign mul     = mul_q;

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed corner cases, start-while-busy, mid-run reset,
// and randomized signed operands against a plain-arithmetic product model.
module tb_mult_booth;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic             Clk;
  logic             reset;
  logic             workMult;
  logic [W-1:0]     oper_A;
  logic [W-1:0]     oper_B;
  logic             busy;
  logic             endMult;
  logic [2*W-1:0]   mul;

  int n_pass;
  int n_total;

  mult_booth #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .workMult (workMult),
    .oper_A   (oper_A),
    .oper_B   (oper_B),
    .busy     (busy),
    .endMult  (endMult),
    .mul      (mul)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Start one multiplication; optionally hold workMult and scramble operands while running.
  task automatic do_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input bit scramble, input bit verbose);
    int lat;
    logic [63:0] exp;
    exp = ref_prod(a, b);
    @(negedge Clk);
    oper_A   = a;
    oper_B   = b;
    workMult = 1'b1;
    @(posedge Clk); #1;
    if (!hold) workMult = 1'b0;
    lat = 0;
    for (int n = 1; n <= LAT + 8; n++) begin
      @(posedge Clk); #1;
      if (scramble) begin
        oper_A = $urandom;
        oper_B = $urandom;
      end
      if (endMult) begin
        lat = n;
        break;
      end
    end
    if (verbose) chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    else if (lat == 0) chk({tag, "_timeout"}, 64'(lat), 64'(LAT));
    chk({tag, "_mul"}, mul, exp);
    if (verbose)
      $display("%s: A=%h B=%h mul=%h exp=%h lat=%0d", tag, a, b, mul, exp, lat);
    @(posedge Clk); #1;
    chk({tag, "_pulse_width"}, 64'(endMult), 64'd0);
    if (verbose) chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int seen;
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b0;
    workMult = 1'b0;
    oper_A   = '0;
    oper_B   = '0;

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_end", 64'(endMult), 64'd0);
    chk("rst_mul", mul, 64'd0);
    @(negedge Clk);
    reset = 1'b1;

    do_mult("pos", 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    chk("pos_const", mul, 64'h0000_0000_0000_000C);
    do_mult("negneg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    chk("negneg_const", mul, 64'h0000_0000_0000_0001);
    do_mult("minmin", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    chk("minmin_const", mul, 64'h4000_0000_0000_0000);
    do_mult("maxmin", 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    chk("maxmin_const", mul, 64'hC000_0000_8000_0000);

    // Start held high for the whole run, operands scrambled mid-run.
    do_mult("hold", 32'd1234567, 32'hFFFF_F000, 1'b1, 1'b1, 1'b1);
    @(posedge Clk); #1;
    chk("hold_restart_busy", 64'(busy), 64'd1);
    workMult = 1'b0;
    seen = 0;
    for (int n = 0; n < LAT + 4; n++) begin
      @(posedge Clk); #1;
      if (endMult) seen++;
    end
    chk("hold_restart_pulses", 64'(seen), 64'd1);
    chk("hold_restart_idle", 64'(busy), 64'd0);

    // Reset pulsed low at RUN cycle 10.
    @(negedge Clk);
    oper_A   = 32'd9;
    oper_B   = 32'd11;
    workMult = 1'b1;
    @(posedge Clk); #1;
    workMult = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mul", mul, 64'd0);
    chk("abort_end", 64'(endMult), 64'd0);
    @(negedge Clk);
    reset = 1'b1;
    seen = 0;
    for (int n = 0; n < LAT + 4; n++) begin
      @(posedge Clk); #1;
      if (endMult) seen++;
    end
    chk("abort_no_pulse", 64'(seen), 64'd0);
    do_mult("post_rst", 32'd5, -32'sd7, 1'b0, 1'b0, 1'b1);
    chk("post_rst_const", mul, 64'hFFFF_FFFF_FFFF_FFDD);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'h8000_0000;
        2: ra = 32'h7FFF_FFFF;
        3: rb = '0;
        default: ;
      endcase
      do_mult($sformatf("rnd%0d", i), ra, rb, 1'b0, 1'b0, 1'b0);
      $display("rnd%0d: A=%h B=%h mul=%h", i, ra, rb, mul);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
